pe2ddr_sched: RTL and testbench

Queued instruction scheduler for the PE-to-DDR write-back path. It buffers write-back instructions, decodes each one into configurations for the data gatherer (dg), the accumulation buffer (ab) and one of DDR_CH DDR write channels, and pulses their starts. It tracks per-unit completion before issuing the next instruction. It sits between the top-level instruction dispatcher and the dg, ab and DDR writer units.

---
 rtl/pe2ddr_sched.sv | 262 ++++++++++++++++++++++++++
 tb/tb_pe2ddr_sched.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe2ddr_sched.sv
// ============================================================================
// Module      : pe2ddr_sched
// Description : Queued write-back instruction scheduler driving the data
//               gatherer, accumulation buffer and DDR_CH DDR write channels.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe2ddr_sched #(
    parameter int DDR_CH     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int INST_W     = 64,
    parameter int DDR_ADDR_W = 32,
    parameter int BURST_W    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [3:0]                   layer_type,
    input  logic [3:0]                   out_ch_seg,
    input  logic [7:0]                   img_width,
    input  logic [INST_W-1:0]            ins,
    input  logic                         ins_valid,
    output logic                         ins_ready,
    output logic                         dg_start,
    input  logic                         dg_done,
    output logic [3:0]                   dg_conf_pix_num,
    output logic [3:0]                   dg_conf_row_num,
    output logic [5:0]                   dg_conf_shift,
    output logic [1:0]                   dg_conf_pe_sel,
    output logic                         ab_start,
    input  logic                         ab_done,
    output logic [1:0]                   ab_conf_trans_type,
    output logic [7:0]                   ab_conf_trans_num,
    output logic [1:0]                   ab_conf_grp_sel,
    output logic [DDR_CH-1:0]            ddr_start,
    input  logic [DDR_CH-1:0]            ddr_done,
    output logic [DDR_CH*DDR_ADDR_W-1:0] ddr_st_addr,
    output logic [DDR_CH*BURST_W-1:0]    ddr_burst,
    output logic [DDR_CH*DDR_ADDR_W-1:0] ddr_step,
    output logic [DDR_CH*BURST_W-1:0]    ddr_burst_num,
    output logic                         busy,
    output logic                         err_opcode,
    output logic [15:0]                  issue_cnt
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CH_W  = (DDR_CH > 1) ? $clog2(DDR_CH) : 1;
    // Queue entries keep only the decoded fields: {opcode,buf_id,size,shift,st_addr}
    localparam int c_ENT_W = 56;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                r_state;
    logic [c_ENT_W-1:0]    r_mem [FIFO_DEPTH];
    logic [c_PTR_W:0]      r_wptr;
    logic [c_PTR_W:0]      r_rptr;
    logic                  r_illegal;
    logic [DDR_CH+1:0]     r_pending;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic [c_ENT_W-1:0]    w_ent_in;
    logic [c_ENT_W-1:0]    w_head;

    logic [3:0]            w_opcode;
    logic [5:0]            w_buf_id;
    logic [7:0]            w_size;
    logic [3:0]            w_row;
    logic [3:0]            w_pix;
    logic [5:0]            w_shift;
    logic [c_CH_W-1:0]     w_ch;
    logic [DDR_CH-1:0]     w_ch_oh;
    logic                  w_is_feat;
    logic                  w_is_param;
    logic                  w_is_illegal;
    logic                  w_dg_en;
    logic                  w_ab_en;

    logic [63:0]           w_pix_p1;
    logic [63:0]           w_size_p1;
    logic [63:0]           w_feat_burst;
    logic [63:0]           w_feat_step;
    logic [63:0]           w_prm_len;
    logic [63:0]           w_burst64;
    logic [63:0]           w_step64;
    logic [63:0]           w_bnum64;
    logic [63:0]           w_addr64;

    logic [DDR_CH+1:0]     w_done;
    logic [DDR_CH+1:0]     w_pend_next;
    logic                  w_unused;

    // ------------------------------------------------------------------
    // Instruction queue
    // ------------------------------------------------------------------
    assign w_empty  = (r_wptr == r_rptr);
    assign w_full   = (r_wptr[c_PTR_W] != r_rptr[c_PTR_W]) &&
                      (r_wptr[c_PTR_W-1:0] == r_rptr[c_PTR_W-1:0]);
    assign ins_ready = !w_full && !rst;
    assign w_push   = ins_valid && ins_ready;
    assign w_pop    = (r_state == S_IDLE) && !w_empty;
    assign w_ent_in = {ins[61:52], ins[47:40], ins[37:0]};
    assign w_head   = r_mem[r_rptr[c_PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wptr[c_PTR_W-1:0]] <= w_ent_in;
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Decode of the queue head
    // ------------------------------------------------------------------
    assign w_opcode = w_head[55:52];
    assign w_buf_id = w_head[51:46];
    assign w_size   = w_head[45:38];
    assign w_row    = w_head[45:42];
    assign w_pix    = w_head[41:38];
    assign w_shift  = w_head[37:32];

    generate
        if (DDR_CH > 1) begin : g_ch_multi
            assign w_ch = w_buf_id[2 +: c_CH_W];
        end else begin : g_ch_single
            assign w_ch = '0;
        end
    endgenerate

    assign w_ch_oh      = DDR_CH'(1) << w_ch;
    assign w_is_feat    = (w_opcode[3:2] == 2'b00);
    assign w_is_param   = w_opcode[3];
    assign w_is_illegal = (w_opcode[3:2] == 2'b01);
    assign w_dg_en      = (w_opcode == 4'd0);
    assign w_ab_en      = w_is_feat;

    // Wide intermediates keep the products exact before port truncation
    assign w_pix_p1     = {60'd0, w_pix} + 64'd1;
    assign w_size_p1    = {56'd0, w_size} + 64'd1;
    assign w_feat_burst = (w_pix_p1 * {60'd0, out_ch_seg}) << 5;
    assign w_feat_step  = (w_pix_p1 * {56'd0, img_width}) << 5;
    assign w_prm_len    = layer_type[1] ? w_size_p1 : (w_size_p1 << 5);

    assign w_burst64 = w_is_param ? w_prm_len : w_feat_burst;
    assign w_step64  = w_is_param ? w_prm_len : w_feat_step;
    assign w_bnum64  = w_is_param ? (layer_type[0] ? 64'd2 : 64'd0)
                                  : {60'd0, w_row};
    assign w_addr64  = {32'd0, w_head[31:0]};

    assign w_done      = {ddr_done, ab_done, dg_done};
    assign w_pend_next = r_pending & ~w_done;

    assign busy = !w_empty || (r_state != S_IDLE);

    assign w_unused = &{1'b0, ins, layer_type[3:2]};

    // ------------------------------------------------------------------
    // Issue FSM with registered starts and configuration
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state            <= S_IDLE;
            r_illegal          <= 1'b0;
            r_pending          <= '0;
            dg_start           <= 1'b0;
            ab_start           <= 1'b0;
            ddr_start          <= '0;
            dg_conf_pix_num    <= '0;
            dg_conf_row_num    <= '0;
            dg_conf_shift      <= '0;
            dg_conf_pe_sel     <= '0;
            ab_conf_trans_type <= '0;
            ab_conf_trans_num  <= '0;
            ab_conf_grp_sel    <= '0;
            ddr_st_addr        <= '0;
            ddr_burst          <= '0;
            ddr_step           <= '0;
            ddr_burst_num      <= '0;
            err_opcode         <= 1'b0;
            issue_cnt          <= '0;
        end else begin
            dg_start  <= 1'b0;
            ab_start  <= 1'b0;
            ddr_start <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state <= S_ISSUE;
                        if (w_is_illegal) begin
                            r_illegal  <= 1'b1;
                            err_opcode <= 1'b1;
                        end else begin
                            r_illegal <= 1'b0;
                            dg_start  <= w_dg_en;
                            ab_start  <= w_ab_en;
                            ddr_start <= w_ch_oh;
                            if (w_dg_en) begin
                                dg_conf_pix_num <= w_pix;
                                dg_conf_row_num <= w_row;
                                dg_conf_shift   <= w_shift;
                                dg_conf_pe_sel  <= layer_type[0] ? 2'b00 : w_buf_id[1:0];
                            end
                            if (w_ab_en) begin
                                ab_conf_trans_type <= w_opcode[1:0];
                                ab_conf_trans_num  <= w_size;
                                ab_conf_grp_sel    <= w_buf_id[1:0];
                            end
                            for (int c = 0; c < DDR_CH; c++) begin
                                if (w_ch_oh[c]) begin
                                    ddr_st_addr[c*DDR_ADDR_W +: DDR_ADDR_W]  <= w_addr64[DDR_ADDR_W-1:0];
                                    ddr_step[c*DDR_ADDR_W +: DDR_ADDR_W]     <= w_step64[DDR_ADDR_W-1:0];
                                    ddr_burst[c*BURST_W +: BURST_W]          <= w_burst64[BURST_W-1:0];
                                    ddr_burst_num[c*BURST_W +: BURST_W]      <= w_bnum64[BURST_W-1:0];
                                end
                            end
                        end
                    end
                end
                S_ISSUE: begin
                    // An illegal opcode passes through here only to return to IDLE
                    if (r_illegal) begin
                        r_illegal <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        issue_cnt <= issue_cnt + 16'd1;
                        r_pending <= {ddr_start, ab_start, dg_start};
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_pending <= w_pend_next;
                    if (w_pend_next == '0) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pe2ddr_sched.sv
// ============================================================================
// Module      : tb_pe2ddr_sched
// Description : Directed self-checking bench for pe2ddr_sched.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pe2ddr_sched;

    localparam int DDR_CH     = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int INST_W     = 64;
    localparam int DDR_ADDR_W = 32;
    localparam int BURST_W    = 16;

    logic                         clk = 1'b0;
    logic                         rst = 1'b1;
    logic [3:0]                   layer_type = '0;
    logic [3:0]                   out_ch_seg = '0;
    logic [7:0]                   img_width = '0;
    logic [INST_W-1:0]            ins = '0;
    logic                         ins_valid = 1'b0;
    logic                         ins_ready;
    logic                         dg_start;
    logic                         dg_done = 1'b0;
    logic [3:0]                   dg_conf_pix_num;
    logic [3:0]                   dg_conf_row_num;
    logic [5:0]                   dg_conf_shift;
    logic [1:0]                   dg_conf_pe_sel;
    logic                         ab_start;
    logic                         ab_done = 1'b0;
    logic [1:0]                   ab_conf_trans_type;
    logic [7:0]                   ab_conf_trans_num;
    logic [1:0]                   ab_conf_grp_sel;
    logic [DDR_CH-1:0]            ddr_start;
    logic [DDR_CH-1:0]            ddr_done = '0;
    logic [DDR_CH*DDR_ADDR_W-1:0] ddr_st_addr;
    logic [DDR_CH*BURST_W-1:0]    ddr_burst;
    logic [DDR_CH*DDR_ADDR_W-1:0] ddr_step;
    logic [DDR_CH*BURST_W-1:0]    ddr_burst_num;
    logic                         busy;
    logic                         err_opcode;
    logic [15:0]                  issue_cnt;

    int tests = 0;
    int fails = 0;

    pe2ddr_sched #(
        .DDR_CH     (DDR_CH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .INST_W     (INST_W),
        .DDR_ADDR_W (DDR_ADDR_W),
        .BURST_W    (BURST_W)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .layer_type         (layer_type),
        .out_ch_seg         (out_ch_seg),
        .img_width          (img_width),
        .ins                (ins),
        .ins_valid          (ins_valid),
        .ins_ready          (ins_ready),
        .dg_start           (dg_start),
        .dg_done            (dg_done),
        .dg_conf_pix_num    (dg_conf_pix_num),
        .dg_conf_row_num    (dg_conf_row_num),
        .dg_conf_shift      (dg_conf_shift),
        .dg_conf_pe_sel     (dg_conf_pe_sel),
        .ab_start           (ab_start),
        .ab_done            (ab_done),
        .ab_conf_trans_type (ab_conf_trans_type),
        .ab_conf_trans_num  (ab_conf_trans_num),
        .ab_conf_grp_sel    (ab_conf_grp_sel),
        .ddr_start          (ddr_start),
        .ddr_done           (ddr_done),
        .ddr_st_addr        (ddr_st_addr),
        .ddr_burst          (ddr_burst),
        .ddr_step           (ddr_step),
        .ddr_burst_num      (ddr_burst_num),
        .busy               (busy),
        .err_opcode         (err_opcode),
        .issue_cnt          (issue_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [3:0] op, input logic [5:0] bid,
                                       input logic [7:0] size, input logic [5:0] sh,
                                       input logic [31:0] addr);
        return {2'b00, op, bid, 4'h0, size, 2'b00, sh, addr};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset ----------------
        tick();
        tick();
        chk("rst_ready", ins_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_opcode, 0);
        chk("rst_cnt", issue_cnt, 0);
        chk("rst_starts", {dg_start, ab_start, ddr_start}, 0);
        chk("rst_burst", ddr_burst, 0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", ins_ready, 1);

        // ---------------- feature op 0 ----------------
        layer_type = 4'b0000;
        out_ch_seg = 4'd2;
        img_width  = 8'd16;
        ins = mk(4'd0, 6'h05, 8'h73, 6'h0A, 32'h1000_0000);
        ins_valid = 1'b1;
        tick();
        ins_valid = 1'b0;
        chk("t1_no_early_start", {dg_start, ab_start, ddr_start}, 0);
        chk("t1_busy", busy, 1);
        tick();
        chk("t1_starts", {dg_start, ab_start, ddr_start}, 4'b1110);
        chk("t1_burst1", ddr_burst[16 +: 16], 256);
        chk("t1_step1", ddr_step[32 +: 32], 2048);
        chk("t1_bnum1", ddr_burst_num[16 +: 16], 7);
        chk("t1_addr1", ddr_st_addr[32 +: 32], 32'h1000_0000);
        chk("t1_burst0_untouched", ddr_burst[0 +: 16], 0);
        chk("t1_dg_conf", {dg_conf_pix_num, dg_conf_row_num, dg_conf_shift, dg_conf_pe_sel},
            {4'd3, 4'd7, 6'h0A, 2'd1});
        chk("t1_ab_conf", {ab_conf_trans_type, ab_conf_trans_num, ab_conf_grp_sel},
            {2'd0, 8'h73, 2'd1});
        chk("t1_cnt_pre", issue_cnt, 0);
        tick();
        chk("t1_starts_one_cycle", {dg_start, ab_start, ddr_start}, 0);
        chk("t1_cnt", issue_cnt, 1);
        dg_done = 1'b1;
        tick();
        dg_done = 1'b0;
        chk("t1_busy_after_dg", busy, 1);
        ab_done = 1'b1;
        tick();
        ab_done = 1'b0;
        chk("t1_busy_after_ab", busy, 1);
        ddr_done = 2'b10;
        tick();
        ddr_done = 2'b00;
        chk("t1_busy_drop", busy, 0);

        // ---------------- param op, layer_type[0] ----------------
        layer_type = 4'b0001;
        ins = mk(4'b1000, 6'h00, 8'd9, 6'h00, 32'h0000_2000);
        ins_valid = 1'b1;
        tick();
        ins_valid = 1'b0;
        tick();
        chk("t2a_starts", {dg_start, ab_start, ddr_start}, 4'b0001);
        chk("t2a_burst0", ddr_burst[0 +: 16], 320);
        chk("t2a_step0", ddr_step[0 +: 32], 320);
        chk("t2a_bnum0", ddr_burst_num[0 +: 16], 2);
        chk("t2a_burst1_held", ddr_burst[16 +: 16], 256);
        chk("t2a_dg_held", dg_conf_pix_num, 3);
        chk("t2a_ab_held", ab_conf_trans_num, 8'h73);
        tick();
        ddr_done = 2'b01;
        tick();
        ddr_done = 2'b00;
        chk("t2a_busy", busy, 0);
        chk("t2a_cnt", issue_cnt, 2);

        // ---------------- param op, layer_type[1] ----------------
        layer_type = 4'b0010;
        ins = mk(4'b1000, 6'h04, 8'd9, 6'h00, 32'h0000_2400);
        ins_valid = 1'b1;
        tick();
        ins_valid = 1'b0;
        tick();
        chk("t2b_starts", {dg_start, ab_start, ddr_start}, 4'b0010);
        chk("t2b_burst1", ddr_burst[16 +: 16], 10);
        chk("t2b_step1", ddr_step[32 +: 32], 10);
        chk("t2b_bnum1", ddr_burst_num[16 +: 16], 0);
        chk("t2b_burst0_held", ddr_burst[0 +: 16], 320);
        tick();
        ddr_done = 2'b10;
        tick();
        ddr_done = 2'b00;
        chk("t2b_cnt", issue_cnt, 3);

        // ---------------- illegal opcode ----------------
        layer_type = 4'b0000;
        ins = mk(4'b0100, 6'h00, 8'h00, 6'h00, 32'h0);
        ins_valid = 1'b1;
        tick();
        ins_valid = 1'b0;
        chk("t3_err_not_yet", err_opcode, 0);
        tick();
        chk("t3_err_set", err_opcode, 1);
        chk("t3_no_starts", {dg_start, ab_start, ddr_start}, 0);
        tick();
        chk("t3_idle", busy, 0);
        chk("t3_cnt", issue_cnt, 3);

        // ---------------- valid op after illegal, spurious dg_done ----------------
        ins = mk(4'b0001, 6'h02, 8'h21, 6'h00, 32'h0000_3000);
        ins_valid = 1'b1;
        tick();
        ins_valid = 1'b0;
        tick();
        chk("t3v_starts", {dg_start, ab_start, ddr_start}, 4'b0101);
        chk("t3v_ab_conf", {ab_conf_trans_type, ab_conf_trans_num, ab_conf_grp_sel},
            {2'd1, 8'h21, 2'd2});
        chk("t3v_burst0", ddr_burst[0 +: 16], 128);
        chk("t3v_step0", ddr_step[0 +: 32], 1024);
        chk("t3v_bnum0", ddr_burst_num[0 +: 16], 2);
        chk("t3v_err_sticky", err_opcode, 1);
        chk("t3v_dg_held", dg_conf_pix_num, 3);
        tick();
        dg_done = 1'b1;
        tick();
        dg_done = 1'b0;
        chk("t6_spurious_ignored", busy, 1);
        ab_done  = 1'b1;
        ddr_done = 2'b01;
        tick();
        ab_done  = 1'b0;
        ddr_done = 2'b00;
        chk("t6_simul_done", busy, 0);
        chk("t6_cnt", issue_cnt, 4);

        // ---------------- queue fill and ordering ----------------
        layer_type = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            ins = mk(4'b1000, 6'h00, 8'(i), 6'h00, 32'hA0 + 32'(i));
            ins_valid = 1'b1;
            tick();
        end
        ins_valid = 1'b0;
        chk("t4_full", ins_ready, 0);
        chk("t4_first_addr", ddr_st_addr[0 +: 32], 32'hA0);
        chk("t4_cnt_one_issued", issue_cnt, 5);
        for (int k = 0; k < 4; k++) begin
            ddr_done = 2'b01;
            tick();
            ddr_done = 2'b00;
            chk("t4_gap", ddr_start, 0);
            tick();
            chk("t4_start", ddr_start, 2'b01);
            chk("t4_order_addr", ddr_st_addr[0 +: 32], 32'hA0 + 32'(k + 1));
            chk("t4_order_burst", ddr_burst[0 +: 16], 16'(k + 2));
            if (k == 0) chk("t4_ready_again", ins_ready, 1);
            tick();
        end
        ddr_done = 2'b01;
        tick();
        ddr_done = 2'b00;
        chk("t4_drained", busy, 0);
        chk("t4_cnt", issue_cnt, 9);

        // ---------------- reset during WAIT ----------------
        for (int i = 0; i < 3; i++) begin
            ins = mk(4'b1000, 6'h00, 8'd0, 6'h00, 32'hB0 + 32'(i));
            ins_valid = 1'b1;
            tick();
        end
        ins_valid = 1'b0;
        chk("t5_busy_pre", busy, 1);
        chk("t5_cnt_pre", issue_cnt, 10);
        rst = 1'b1;
        tick();
        chk("t5_ready_in_rst", ins_ready, 0);
        chk("t5_busy_rst", busy, 0);
        chk("t5_cnt_rst", issue_cnt, 0);
        chk("t5_err_rst", err_opcode, 0);
        chk("t5_cfg_rst", ddr_st_addr, 0);
        rst = 1'b0;
        ddr_done = 2'b01;
        dg_done  = 1'b1;
        ab_done  = 1'b1;
        tick();
        ddr_done = 2'b00;
        dg_done  = 1'b0;
        ab_done  = 1'b0;
        chk("t5_late_done_0", {dg_start, ab_start, ddr_start}, 0);
        tick();
        chk("t5_late_done_1", {dg_start, ab_start, ddr_start}, 0);
        chk("t5_idle", busy, 0);
        tick();
        chk("t5_cnt_stays", issue_cnt, 0);
        ins = mk(4'b1000, 6'h00, 8'd0, 6'h00, 32'hC0);
        ins_valid = 1'b1;
        tick();
        ins_valid = 1'b0;
        tick();
        chk("t5_fresh_start", ddr_start, 2'b01);
        chk("t5_queue_flushed", ddr_st_addr[0 +: 32], 32'hC0);
        tick();
        ddr_done = 2'b01;
        tick();
        ddr_done = 2'b00;
        chk("t5_final_idle", busy, 0);
        chk("t5_final_cnt", issue_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
